// File: rtl/mul_inner_pkg.sv
// Shared types for the mul_inner_acc PE: FSM states, stream mode and result width helper.
package mul_inner_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      UNIPOLAR = 1'b0,
      BIPOLAR  = 1'b1
   } mode_t;

   // Signed result needs one bit for ones == 2^WIDTH and one for the sign.
   function automatic int res_w(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/mul_inner_core.sv
// Rate-coded product bit: weight vs forwarded random numbers, gated by the stream bit.
// Purely combinational; the mode input is the window-latched mode.
module mul_inner_core
   import mul_inner_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] weight,
   input  logic [WIDTH-1:0] rand_w,
   input  logic [WIDTH-1:0] rand_w_inv,
   input  logic             stream_bit,
   input  logic             mode,
   output logic             prod_bit
);

   logic bit_w;
   logic bit_w_inv;

   assign bit_w     = weight > rand_w;
   assign bit_w_inv = weight <= rand_w_inv;

   // Bipolar: a 0 stream bit selects the inverse-stream comparison (XNOR semantics).
   always_comb begin
      prod_bit = stream_bit & bit_w;
      if (mode == BIPOLAR) begin
         prod_bit = stream_bit ? bit_w : bit_w_inv;
      end
   end

endmodule

// File: rtl/mul_inner_acc.sv
// Systolic unary PE with windowed accumulator; forwarding latency 1, result N+1 cycles after start.
// No backpressure: start is ignored while busy. MUL_INNER_ZERO_SKIP_EN skips zero-weight unipolar windows.
module mul_inner_acc
   import mul_inner_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int RES_W = res_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_mode,
   input  logic             i_w_load,
   input  logic [WIDTH-1:0] i_data_w,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_len,
   input  logic             i_bit_i,
   input  logic [WIDTH-1:0] i_randW,
   input  logic [WIDTH-1:0] i_randW_inv,
   output logic             o_bit_i,
   output logic [WIDTH-1:0] o_randW,
   output logic [WIDTH-1:0] o_randW_inv,
   output logic             o_bit,
   output logic             o_busy,
   output logic             o_done,
   output logic [RES_W-1:0] o_result
);

   localparam int CNT_W = WIDTH + 1;

   state_t           state;
   state_t           state_nxt;
   mode_t            mode_q;
   logic [WIDTH-1:0] w_q;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] win_len;
   logic [CNT_W-1:0] ones;
   logic [CNT_W-1:0] ones_inc;
   logic [CNT_W-1:0] len_eff;
   logic [RES_W-1:0] final_res;
   logic             take_start;
   logic             last;
   logic             skip;

   mul_inner_core #(.WIDTH(WIDTH)) u_core (
      .weight     (w_q),
      .rand_w     (o_randW),
      .rand_w_inv (o_randW_inv),
      .stream_bit (i_bit_i),
      .mode       (mode_q),
      .prod_bit   (o_bit)
   );

   // A zero length means a full 2^WIDTH window, hence the extra counter bit.
   assign len_eff    = (i_len == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, i_len};
   assign take_start = i_start && ((state == IDLE) || (state == DONE));
   assign last       = (remaining == CNT_W'(1));
   assign ones_inc   = ones + CNT_W'(o_bit);

   // Bipolar value is 2*ones - N; the wrap in RES_W bits yields the signed result.
   assign final_res  = (mode_q == BIPOLAR) ? ({ones_inc, 1'b0} - {1'b0, win_len})
                                           : {1'b0, ones_inc};

`ifdef MUL_INNER_ZERO_SKIP_EN
   logic [WIDTH-1:0] w_eff;
   assign w_eff = i_w_load ? i_data_w : w_q;
   assign skip  = (w_eff == '0) && (i_mode == UNIPOLAR);
`else
   assign skip  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         RUN:     state_nxt = last ? DONE : RUN;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (take_start) begin
         state_nxt = skip ? DONE : RUN;
      end
   end

   always_comb begin
      o_busy = (state == RUN);
      o_done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_bit_i     <= 1'b0;
         o_randW     <= '0;
         o_randW_inv <= '0;
         w_q         <= '0;
         mode_q      <= UNIPOLAR;
         remaining   <= '0;
         win_len     <= '0;
         ones        <= '0;
         o_result    <= '0;
      end else begin
         o_bit_i     <= i_bit_i;
         o_randW     <= i_randW;
         o_randW_inv <= i_randW_inv;
         if (i_w_load && (state != RUN)) begin
            w_q <= i_data_w;
         end
         if (take_start) begin
            mode_q    <= mode_t'(i_mode);
            remaining <= len_eff;
            win_len   <= len_eff;
            ones      <= '0;
            if (skip) begin
               o_result <= '0;
            end
         end else if (state == RUN) begin
            ones      <= ones_inc;
            remaining <= remaining - CNT_W'(1);
            if (last) begin
               o_result <= final_res;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_inner_acc.sv
// Scoreboard bench for mul_inner_acc (WIDTH=8): windows are scored by a counting model,
// a separate monitor pops expectations on o_done and checks forwarding every cycle.
module tb_mul_inner_acc;

   localparam int W  = 8;
   localparam int RW = W + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_mode = 1'b0;
   logic          i_w_load = 1'b0;
   logic [W-1:0]  i_data_w = '0;
   logic          i_start = 1'b0;
   logic [W-1:0]  i_len = '0;
   logic          i_bit_i = 1'b0;
   logic [W-1:0]  i_randW = '0;
   logic [W-1:0]  i_randW_inv = '0;
   logic          o_bit_i;
   logic [W-1:0]  o_randW;
   logic [W-1:0]  o_randW_inv;
   logic          o_bit;
   logic          o_busy;
   logic          o_done;
   logic [RW-1:0] o_result;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];
   int busy_q[$];
   int w_m = 0;
   int busy_cnt = 0;
   logic [2*W:0] fwd_exp;

   mul_inner_acc #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .i_mode(i_mode), .i_w_load(i_w_load), .i_data_w(i_data_w),
      .i_start(i_start), .i_len(i_len), .i_bit_i(i_bit_i), .i_randW(i_randW),
      .i_randW_inv(i_randW_inv), .o_bit_i(o_bit_i), .o_randW(o_randW),
      .o_randW_inv(o_randW_inv), .o_bit(o_bit), .o_busy(o_busy), .o_done(o_done),
      .o_result(o_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) fwd_exp = rst ? '0 : {i_bit_i, i_randW, i_randW_inv};

   // Monitor: forwarding every cycle, window result and busy length on each done pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt = 0;
         end else begin
            check("forward", int'({o_bit_i, o_randW, o_randW_inv}), int'(fwd_exp));
            if (o_busy) busy_cnt++;
            if (o_done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  check("result", int'($signed(o_result)), exp_q.pop_front());
                  check("busy_cycles", busy_cnt, busy_q.pop_front());
               end
               busy_cnt = 0;
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         i_start  = 1'b0;
         i_w_load = 1'b0;
      end
   endtask

   task automatic load_weight(input int w);
      @(negedge clk);
      i_w_load = 1'b1;
      i_data_w = w[W-1:0];
      w_m      = w;
      @(negedge clk);
      i_w_load = 1'b0;
   endtask

   // bit_sel: 0/1 constant stream bit, 2 random. rand_sel: 0 sweep 0..N-1, 1 random.
   task automatic run_window(input int mode, input int w, input int len, input bit load,
                             input int bit_sel, input int rand_sel, input bit disturb);
      logic [W-1:0] r  [0:256];
      logic [W-1:0] ri [0:256];
      logic         b  [0:256];
      logic         m;
      int           n, ones, exp, exp_busy;
      m = mode[0];
      n = (len == 0) ? 256 : len;
      for (int k = 0; k <= n; k++) begin
         r[k]  = (rand_sel == 0) ? k[W-1:0] : W'($urandom);
         ri[k] = (rand_sel == 0) ? k[W-1:0] : W'($urandom);
         b[k]  = (bit_sel == 2) ? 1'($urandom) : (bit_sel == 1);
      end
      if (load) w_m = w;
      ones = 0;
      for (int k = 0; k < n; k++) begin
         if (mode == 0) ones += (b[k] && (w_m > int'(r[k]))) ? 1 : 0;
         else if (b[k]) ones += (w_m > int'(r[k])) ? 1 : 0;
         else ones += (w_m <= int'(ri[k])) ? 1 : 0;
      end
      exp      = (mode == 0) ? ones : 2 * ones - n;
      exp_busy = n;
`ifdef MUL_INNER_ZERO_SKIP_EN
      if (mode == 0 && w_m == 0) exp_busy = 0;
`endif
      exp_q.push_back(exp);
      busy_q.push_back(exp_busy);
      @(negedge clk);
      i_start     = 1'b1;
      i_mode      = m;
      i_len       = len[W-1:0];
      i_w_load    = load;
      i_data_w    = w[W-1:0];
      i_randW     = r[0];
      i_randW_inv = ri[0];
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         i_start     = disturb && (k == 1);
         i_w_load    = disturb && (k == 1);
         i_data_w    = '0;
         i_mode      = (disturb && (k == 1)) ? ~m : m;
         i_bit_i     = b[k];
         i_randW     = r[k+1];
         i_randW_inv = ri[k+1];
      end
      i_start  = 1'b0;
      i_w_load = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(o_busy), 0);
      check("rst_done", int'(o_done), 0);
      check("rst_result", int'(o_result), 0);
      check("rst_fwd", int'({o_bit_i, o_randW, o_randW_inv}), 0);
      rst = 1'b0;
      idle(2);

      run_window(0, 128, 0, 1'b1, 1, 0, 1'b0);   // unipolar sweep -> 128
      idle(2);
      run_window(1, 192, 0, 1'b1, 1, 0, 1'b0);   // bipolar, bit 1 -> 128
      idle(1);
      run_window(1, 192, 0, 1'b1, 0, 0, 1'b0);   // bipolar, bit 0 -> -128
      idle(3);
      run_window(0, 255, 4, 1'b1, 1, 0, 1'b0);   // short window -> 4
      run_window(0, 255, 4, 1'b0, 1, 0, 1'b1);   // back-to-back, mid-RUN start/load ignored
      run_window(1, 100, 1, 1'b1, 2, 1, 1'b0);   // single-cycle window
      for (int i = 0; i < 3; i++)
         run_window(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                    int'($urandom_range(1, 20)), 1'b1, 2, 1, 1'b0);
      idle(3);

      // Reset in the middle of a window: everything clears, no done pulse.
      @(negedge clk);
      i_start  = 1'b1;
      i_len    = 8'd50;
      i_w_load = 1'b1;
      i_data_w = 8'd200;
      idle(4);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", int'(o_busy), 0);
      check("midrst_done", int'(o_done), 0);
      check("midrst_result", int'(o_result), 0);
      check("midrst_fwd", int'({o_bit_i, o_randW, o_randW_inv}), 0);
      rst = 1'b0;
      w_m = 0;
      idle(8);

      run_window(0, 0, 100, 1'b1, 1, 1, 1'b0);   // zero weight, unipolar
      idle(2);
      load_weight(77);
      run_window(1, 0, 30, 1'b0, 2, 1, 1'b0);    // weight from an earlier IDLE load
      for (int i = 0; i < 8; i++) begin
         run_window(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 7)) == 0 ? 0 : int'($urandom_range(1, 40)),
                    1'($urandom), 2, 1, 1'b0);
         idle(int'($urandom_range(0, 2)));
      end

      for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain", exp_q.size(), 0);
      idle(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_inner_acc.md
Name: mul_inner_acc

Overview:
- Next-generation systolic PE for the unary/rate-coded GEMM array.
- Holds one stationary weight and compares it against a forwarded random stream to produce a weight bit each cycle.
- Gates that bit with the incoming input bit: AND in unipolar mode, select/XNOR in bipolar mode.
- Forwards the random numbers and input bit to the neighbour PE one cycle later.
- Adds what the previous PE lacked: runtime mode select, a weight-load handshake, and a windowed on-PE accumulator with start/busy/done control that returns a binary partial product.

Parameters:
- WIDTH, 16, bit width of weight and random numbers; window length up to 2^WIDTH cycles.
- RES_W, WIDTH+2, width of signed result; fixed by WIDTH, not to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_mode  in  1  0 = unipolar, 1 = bipolar; latched at start
- i_w_load  in  1  load i_data_w into weight register
- i_data_w  in  WIDTH  weight value, unsigned
- i_start  in  1  start accumulation window
- i_len  in  WIDTH  window length in cycles; 0 means 2^WIDTH
- i_bit_i  in  1  input stream bit
- i_randW  in  WIDTH  random number from upstream PE
- i_randW_inv  in  WIDTH  inverse-stream random number from upstream PE
- o_bit_i  out  1  i_bit_i delayed one cycle, to downstream PE
- o_randW  out  WIDTH  i_randW delayed one cycle
- o_randW_inv  out  WIDTH  i_randW_inv delayed one cycle
- o_bit  out  1  product bit, combinational
- o_busy  out  1  high while in RUN
- o_done  out  1  one-cycle pulse when result becomes valid
- o_result  out  RES_W  signed accumulated result, held until the next start

Behaviour:
- Reset (rst high at a clk edge):
  - all registers cleared and state goes to IDLE;
  - o_bit_i, o_randW, o_randW_inv, o_busy, o_done, o_result are all 0;
  - weight register is 0 and latched mode is 0.
- Reset asserted mid-RUN aborts the window with no done pulse.
- Forwarding: o_bit_i, o_randW, o_randW_inv are registered copies of their inputs. They update every cycle in every state, and the latency is 1 cycle.
- Comparison uses the registered random values:
  - bitW = w > o_randW;
  - bitW_inv = w <= o_randW_inv.
- o_bit, always driven:
  - unipolar: i_bit_i & bitW;
  - bipolar: i_bit_i ? bitW : bitW_inv.
  - The mode used is the latched mode.
- Weight load: on i_w_load in IDLE or DONE, w <= i_data_w. i_w_load in RUN is ignored.
- State machine, IDLE -> RUN -> DONE:
  - IDLE: on i_start, latch i_mode, load remaining <= i_len (zero maps to 2^WIDTH, so the counter is WIDTH+1 bits wide), clear ones, go to RUN.
  - RUN: o_busy = 1. Each cycle, ones += o_bit and remaining -= 1. In the cycle where remaining == 1, the final bit is counted and the next state is DONE.
  - DONE: o_done = 1 for exactly this one cycle; o_result is updated entering DONE. Next state is IDLE, or RUN if i_start is high, which re-latches as in IDLE.
- First counted cycle is the cycle after the i_start sample. Total RUN cycles = N, where N = i_len, or 2^WIDTH when i_len = 0.
- i_start during RUN is ignored.
- i_start and i_w_load in the same IDLE cycle: the new weight is used for the whole window.
- Result format:
  - unipolar: o_result = ones, zero-extended;
  - bipolar: o_result = 2*ones - N, computed in RES_W signed.
  - ones ranges 0..2^WIDTH (WIDTH+1 bits), so the bipolar range ±2^WIDTH fits RES_W without overflow.
- o_result holds its last value through IDLE and the next RUN, until the next DONE.

Optional Feature:
- Macro: MUL_INNER_ZERO_SKIP_EN.
- Defined: at i_start, if the effective weight is 0 and the mode is unipolar, skip RUN. Go directly to DONE the next cycle with o_result = 0 and o_busy never asserted.
- Not defined: every window runs the full N cycles regardless of weight.

Decomposition:
- Package mul_inner_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - mode enum {UNIPOLAR = 0, BIPOLAR = 1};
  - function computing RES_W from WIDTH.
- Sub-module mul_inner_core holds the combinational comparators plus the mode select producing o_bit. The top level holds the forwarding registers, the FSM and the accumulator.

Test Plan:
- WIDTH=8, w=128, i_randW sweeping 0..255, i_bit_i=1, unipolar, i_len=0 -> o_busy high for 256 cycles, o_done pulse, o_result=128.
- Bipolar, w=192, i_bit_i=1, i_randW sweep, i_len=0 -> o_result=128 (192 ones, 2*192-256).
- Bipolar, w=192, i_bit_i=0, i_randW_inv sweep 0..255, i_len=0 -> o_result=-128 (64 ones).
- i_len=4, w=255, i_bit_i=1, unipolar -> o_busy for exactly 4 cycles, o_result=4.
- Same setup with i_start pulsed mid-RUN, i_w_load=1 and i_data_w=0 mid-RUN -> both ignored, o_result=4.
- Back-to-back windows with i_start held during DONE -> new RUN starts the next cycle, no gap.
- rst mid-RUN -> all outputs 0, no o_done.
- Zero skip: w=0, unipolar, i_len=100.
  - With MUL_INNER_ZERO_SKIP_EN: o_done one cycle after start, o_result=0.
  - Without it: 100 busy cycles, o_result=0.
